// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// The DMEM_MISALIGN_CHECK_EN macro selects the lane/mask error check
// in dmem_responder.
package dmem_pkg;

  localparam int DEFAULT_DEPTH_WORDS = 256;
  localparam int DEFAULT_LATENCY     = 2;

  // Request/response sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  // Request fields latched when the request is accepted.
  typedef struct packed {
    logic        wr;     // write (write wins when ren and wen are both high)
    logic [31:0] addr;   // byte address
    logic [31:0] wdata;  // lane-aligned write data
    logic [3:0]  mask;   // byte-lane enables
    logic        err;    // access error decided at acceptance
  } dmem_req_t;

  // Returns 1 when mask is empty or enables a lane below the start lane.
  function automatic logic misalign_err(input logic [3:0] mask, input logic [1:0] lane);
    logic [3:0] below;
    below = (4'b0001 << lane) - 4'b0001;
    return (mask == 4'b0000) || ((mask & below) != 4'b0000);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between a core (master) and dmem_responder (slave).
interface dmem_responder_if;

  logic        i_req_ren;
  logic        i_req_wen;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic [3:0]  i_req_mask;
  logic        o_req_ready;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;

  modport master (
    output i_req_ren, i_req_wen, i_req_addr, i_req_wdata, i_req_mask,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
  );

  modport slave (
    input  i_req_ren, i_req_wen, i_req_addr, i_req_wdata, i_req_mask,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
  );

endinterface

// File: rtl/dmem_array.sv
// DEPTH_WORDS x 32 storage with byte-enable write and synchronous read.
// The read register returns the pre-write word when read and write hit the
// same edge, and holds zero on any cycle without a read.
module dmem_array import dmem_pkg::*; #(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  localparam int AW         = $clog2(DEPTH_WORDS)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [AW-1:0] i_idx,
  input  logic [31:0]   i_wdata,
  input  logic [3:0]    i_be,
  output logic [31:0]   o_rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_d;
  logic [31:0] rdata_q;

  // Byte-lane write into storage; contents are intentionally not reset.
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_we && i_be[b]) begin
        mem_q[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  // Next read word: stored word on a read, zero otherwise.
  always_comb begin
    rdata_d = 32'h0000_0000;
    if (i_re) begin
      rdata_d = mem_q[i_idx];
    end else begin
      rdata_d = 32'h0000_0000;
    end
  end

  // Read data register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rdata_q <= 32'h0000_0000;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: accepts one read or write in IDLE,
// waits LATENCY cycles, then emits a single-cycle response.
// Optional feature: DMEM_MISALIGN_CHECK_EN flags empty masks and lanes
// enabled below the address byte offset as errors.
module dmem_responder import dmem_pkg::*; #(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int LATENCY     = DEFAULT_LATENCY
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  dmem_responder_if.slave   bus
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_LOAD = 4'((LATENCY >= 2) ? (LATENCY - 2) : 0);

  dmem_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  dmem_req_t   req_q, req_d;
  dmem_req_t   live_s;
  dmem_req_t   cur_s;
  logic        accept_s;
  logic        enter_resp_s;
  logic        mem_we_s;
  logic        mem_re_s;
  logic [31:0] rdata_s;
  logic        unused_addr_s;

  // Request as currently presented on the bus, with its error verdict.
  always_comb begin
    live_s.wr    = bus.i_req_wen;
    live_s.addr  = bus.i_req_addr;
    live_s.wdata = bus.i_req_wdata;
    live_s.mask  = bus.i_req_mask;
`ifdef DMEM_MISALIGN_CHECK_EN
    live_s.err   = misalign_err(bus.i_req_mask, bus.i_req_addr[1:0]);
`else
    live_s.err   = 1'b0;
`endif
  end

  assign accept_s = (bus.i_req_ren | bus.i_req_wen) & (state_q == ST_IDLE);

  // Sequencer: IDLE -> (WAIT ->) RESP -> IDLE with the latency counter.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    enter_resp_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          req_d = live_s;
          if (LATENCY == 1) begin
            state_d      = ST_RESP;
            cnt_d        = 4'd0;
            enter_resp_s = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d      = ST_RESP;
          enter_resp_s = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        req_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
        req_d   = '0;
      end
    endcase
  end

  // State, counter and captured request registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

  // With LATENCY==1 the array is accessed on the accepting edge itself, so
  // the live bus fields are used; otherwise the captured copy.
  assign cur_s = (state_q == ST_IDLE) ? live_s : req_q;

  // Array strobes fire only on the edge entering RESP. Gating with i_rst_n
  // keeps an in-flight request from touching storage while reset is held.
  assign mem_we_s = enter_resp_s &  cur_s.wr & ~cur_s.err & i_rst_n;
  assign mem_re_s = enter_resp_s & ~cur_s.wr & ~cur_s.err & i_rst_n;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_we    (mem_we_s),
    .i_re    (mem_re_s),
    .i_idx   (cur_s.addr[AW+1:2]),
    .i_wdata (cur_s.wdata),
    .i_be    (cur_s.mask),
    .o_rdata (rdata_s)
  );

`ifdef DMEM_MISALIGN_CHECK_EN
  logic rsp_err_q, rsp_err_d;

  // Error flag is loaded on entry to RESP and is therefore high only there.
  always_comb begin
    rsp_err_d = enter_resp_s & cur_s.err;
  end

  // Error flag register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rsp_err_q <= 1'b0;
    end else begin
      rsp_err_q <= rsp_err_d;
    end
  end

  assign bus.o_rsp_err = rsp_err_q;
`else
  assign bus.o_rsp_err = 1'b0;
`endif

  assign bus.o_req_ready = (state_q == ST_IDLE);
  assign bus.o_rsp_valid = (state_q == ST_RESP);
  assign bus.o_rsp_rdata = rdata_s;

  // Address bits outside the word index (byte offset is judged at acceptance).
  assign unused_addr_s = ^{cur_s.addr[31:AW+2], cur_s.addr[1:0],
                           req_q.addr[31:AW+2], req_q.addr[1:0]};

endmodule

// File: tb/tb_dmem_responder.sv
// Directed, table-driven bench for dmem_responder (DEPTH_WORDS=256, LATENCY=2).
module tb_dmem_responder;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dmem_responder_if bus_if();

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus_if)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[13];

`ifdef DMEM_MISALIGN_CHECK_EN
  localparam logic        MIS_ERR    = 1'b1;
  localparam logic [31:0] AFTER_0x13 = 32'hDEABBEEF;
`else
  localparam logic        MIS_ERR    = 1'b0;
  localparam logic [31:0] AFTER_0x13 = 32'hDE77BEEF;
`endif

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the pulse.
  task automatic do_req(input logic ren, input logic wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] mask,
                        output logic [31:0] rdata, output logic err, output int lat);
    check32("ready_before_req", 32'(bus_if.o_req_ready), 32'd1);
    bus_if.i_req_ren   = ren;
    bus_if.i_req_wen   = wen;
    bus_if.i_req_addr  = addr;
    bus_if.i_req_wdata = wdata;
    bus_if.i_req_mask  = mask;
    @(posedge clk);
    #1;
    bus_if.i_req_ren   = 1'b0;
    bus_if.i_req_wen   = 1'b0;
    bus_if.i_req_addr  = ~addr;
    bus_if.i_req_wdata = ~wdata;
    bus_if.i_req_mask  = ~mask;
    lat   = -1;
    rdata = 32'h0;
    err   = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus_if.o_rsp_valid) begin
        lat   = k;
        rdata = bus_if.o_rsp_rdata;
        err   = bus_if.o_rsp_err;
        break;
      end else begin
        check32("rdata_zero_while_waiting", bus_if.o_rsp_rdata, 32'h0);
      end
    end
    @(negedge clk);
    check32("pulse_one_cycle", 32'(bus_if.o_rsp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;

    vecs[0]  = '{1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'h10,  32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 32'h12,  32'h00AB0000, 4'h4, 32'h0,        1'b0};
    vecs[3]  = '{1'b1, 1'b0, 32'h10,  32'h0,        4'hF, 32'hDEABBEEF, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 32'h400, 32'h11223344, 4'hF, 32'h0,        1'b0};
    vecs[5]  = '{1'b1, 1'b0, 32'h0,   32'h0,        4'hF, 32'h11223344, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 32'h410, 32'h0,        4'hF, 32'hDEABBEEF, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 32'h10,  32'hFFFFFFFF, 4'h0, 32'h0,        MIS_ERR};
    vecs[8]  = '{1'b1, 1'b0, 32'h10,  32'h0,        4'hF, 32'hDEABBEEF, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 32'h20,  32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
    vecs[10] = '{1'b1, 1'b0, 32'h20,  32'h0,        4'hF, 32'hCAFEF00D, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 32'h13,  32'h00770000, 4'h4, 32'h0,        MIS_ERR};
    vecs[12] = '{1'b1, 1'b0, 32'h10,  32'h0,        4'hF, AFTER_0x13,   1'b0};

    rst_n              = 1'b0;
    bus_if.i_req_ren   = 1'b0;
    bus_if.i_req_wen   = 1'b0;
    bus_if.i_req_addr  = 32'h0;
    bus_if.i_req_wdata = 32'h0;
    bus_if.i_req_mask  = 4'h0;
    repeat (3) @(negedge clk);
    check32("reset_ready", 32'(bus_if.o_req_ready), 32'd1);
    check32("reset_valid", 32'(bus_if.o_rsp_valid), 32'd0);
    check32("reset_rdata", bus_if.o_rsp_rdata, 32'h0);
    check32("reset_err",   32'(bus_if.o_rsp_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table of single transactions.
    for (int i = 0; i < 13; i++) begin
      do_req(vecs[i].ren, vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].mask, rd, er, lat);
      check32($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
      check32($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check32($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
    end

    // Continuous read request: one acceptance every 3 cycles.
    bus_if.i_req_ren  = 1'b1;
    bus_if.i_req_addr = 32'h20;
    bus_if.i_req_mask = 4'hF;
    for (int s = 0; s < 12; s++) begin
      check32($sformatf("stream%0d_ready", s), 32'(bus_if.o_req_ready), 32'((s % 3) == 0));
      check32($sformatf("stream%0d_valid", s), 32'(bus_if.o_rsp_valid), 32'((s % 3) == 2));
      check32($sformatf("stream%0d_rdata", s), bus_if.o_rsp_rdata,
              ((s % 3) == 2) ? 32'hCAFEF00D : 32'h0);
      @(negedge clk);
    end
    bus_if.i_req_ren = 1'b0;
    check32("stream_end_ready", 32'(bus_if.o_req_ready), 32'd1);
    @(negedge clk);

    // Reset asserted while a write waits: write is dropped.
    bus_if.i_req_wen   = 1'b1;
    bus_if.i_req_addr  = 32'h20;
    bus_if.i_req_wdata = 32'h55555555;
    bus_if.i_req_mask  = 4'hF;
    @(posedge clk);
    #1;
    bus_if.i_req_wen = 1'b0;
    @(negedge clk);
    check32("wait_ready_low", 32'(bus_if.o_req_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check32("midreset_ready", 32'(bus_if.o_req_ready), 32'd1);
    check32("midreset_valid", 32'(bus_if.o_rsp_valid), 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check32("inreset_valid", 32'(bus_if.o_rsp_valid), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check32("postreset_valid", 32'(bus_if.o_rsp_valid), 32'd0);
    do_req(1'b1, 1'b0, 32'h20, 32'h0, 4'hF, rd, er, lat);
    check32("postreset_latency", 32'(lat), 32'd2);
    check32("postreset_word_kept", rd, 32'hCAFEF00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit storage words (power of two, >=4).
REQ-002 SHALL have parameter LATENCY, default 2, cycles from request acceptance to response (legal range 1..15).
REQ-003 SHALL have port i_clk, input, 1: sole clock; all state changes on rising edge.
REQ-004 SHALL have port i_rst_n, input, 1: reset; asynchronous and active-low.
REQ-005 SHALL have port i_req_ren, input, 1: read request from core.
REQ-006 SHALL have port i_req_wen, input, 1: write request from core.
REQ-007 SHALL have port i_req_addr, input, 32: byte address.
REQ-008 SHALL have port i_req_wdata, input, 32: write data, already lane-aligned.
REQ-009 SHALL have port i_req_mask, input, 4: byte-lane enables, bit n = byte lane n.
REQ-010 SHALL have port o_req_ready, output, 1: responder can accept a request this cycle.
REQ-011 SHALL have port o_rsp_valid, output, 1: one-cycle response pulse.
REQ-012 SHALL have port o_rsp_rdata, output, 32: full read word, valid with o_rsp_valid.
REQ-013 SHALL have port o_rsp_err, output, 1: access error, valid with o_rsp_valid.

Function
REQ-014 SHALL accept a request on a rising edge where (i_req_ren | i_req_wen) & o_req_ready; all request fields captured at that edge, later input changes ignored.
REQ-015 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; o_req_ready=1 only in IDLE.
REQ-016 SHALL go IDLE->RESP directly when LATENCY==1; otherwise IDLE->WAIT, loading a 4-bit counter with LATENCY-2, WAIT->RESP when counter==0, else decrement.
REQ-017 SHALL assert o_rsp_valid for exactly the one cycle in RESP, LATENCY cycles after the accepting edge; back-to-back requests therefore sustain one per LATENCY+1 cycles.
REQ-018 SHALL derive word index as addr[log2(DEPTH_WORDS)+1:2]; upper address bits ignored (wrap modulo DEPTH_WORDS).
REQ-019 SHALL commit a write at the edge entering RESP, updating only lanes with mask bit 1; mask 4'b0000 writes nothing.
REQ-020 SHALL return the stored word (pre-write value for the same cycle) on reads, and o_rsp_rdata=0 on writes and whenever o_rsp_valid=0.
REQ-021 SHALL treat ren & wen together as a write (write priority), o_rsp_rdata=0.
REQ-022 SHALL hold o_rsp_err=0 except as defined in REQ-026.

Reset
REQ-023 SHALL on i_rst_n low force FSM=IDLE, counter=0, captured request cleared, o_req_ready=1, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0.
REQ-024 SHALL drop a request in progress when reset asserts mid-WAIT/RESP; no storage write occurs for it.
REQ-025 SHALL NOT reset storage contents; they are undefined after power-up.

Configuration
REQ-026 With DMEM_MISALIGN_CHECK_EN defined, SHALL flag error when mask==0 or any mask bit below lane addr[1:0] is set: o_rsp_err=1, no write, o_rsp_rdata=0; timing unchanged.
REQ-027 Without DMEM_MISALIGN_CHECK_EN, SHALL tie o_rsp_err to 0 and service all requests per mask irrespective of addr[1:0].

Structure
REQ-028 SHALL place FSM state enum, DEFAULT_DEPTH_WORDS and DEFAULT_LATENCY constants in shared package dmem_pkg.
REQ-029 SHALL instantiate one sub-module dmem_array: byte-enable write, synchronous read, DEPTH_WORDS x 32.

Verification
REQ-030 Reset then write addr 0x10, wdata 0xDEADBEEF, mask 4'hF, LATENCY=2 -> o_rsp_valid pulse exactly 2 cycles after accept, rdata=0; read 0x10 -> rdata 0xDEADBEEF.
REQ-031 Write mask 4'b0100 data 0x00AB0000 to 0x12 over 0xDEADBEEF -> subsequent read 0x10 returns 0xDEABBEEF.
REQ-032 Hold ren high continuously -> o_req_ready low during WAIT/RESP, one acceptance per 3 cycles, exactly one pulse per acceptance.
REQ-033 Address 0x400 with DEPTH_WORDS=256 -> aliases word 0 (wrap).
REQ-034 Assert i_rst_n low during WAIT of a write -> no o_rsp_valid, target word unchanged, o_req_ready=1 immediately.
REQ-035 With DMEM_MISALIGN_CHECK_EN, write addr 0x13 mask 4'b0100 -> o_rsp_err=1, memory unchanged; without macro, byte lane 2 written, o_rsp_err=0.
